rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the multiplexer and drives its select input.
- Accepts per-source requests and packet-end flags from in_inputs sources.
- Holds a grant for the full length of a packet, then rotates priority.
- Presents a registered sel/grant pair plus a valid/ready handshake toward the downstream consumer of the mux output.

---
 rtl/rr_mux_arbiter_if.sv | 48 ++++
 rtl/rr_mux_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arbiter_if
//  Description : Bundle of the request / grant / handshake signals between the
//                round-robin arbiter, its requesting sources and the consumer
//                of the mux output.
//  Ports       : req, last, out_ready  - driven by the environment
//                sel, grant, out_valid,
//                busy                  - driven by the arbiter
//  Modports    : master - arbiter side (drives sel/grant/out_valid/busy)
//                slave  - environment side (drives req/last/out_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_mux_arbiter_if #(
  parameter int in_inputs = 16,
  parameter int log2ofin  = ($clog2(in_inputs) <= 0) ? 1 : $clog2(in_inputs)
);

  logic [in_inputs-1:0] req;        // per-source beat available
  logic [in_inputs-1:0] last;       // per-source packet-end flag
  logic                 out_ready;  // downstream accepts the current beat
  logic [log2ofin-1:0]  sel;        // index of the granted source (mux select)
  logic [in_inputs-1:0] grant;      // one-hot grant, zero when idle
  logic                 out_valid;  // mux output beat is valid
  logic                 busy;       // a grant is currently held

  modport master (
    input  req,
    input  last,
    input  out_ready,
    output sel,
    output grant,
    output out_valid,
    output busy
  );

  modport slave (
    output req,
    output last,
    output out_ready,
    input  sel,
    input  grant,
    input  out_valid,
    input  busy
  );

endinterface : rr_mux_arbiter_if
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arbiter
//  Description : Packet-locked round-robin arbiter driving a mux select.
//                In IDLE the first requesting source after the priority
//                pointer is picked and a registered sel/grant pair is loaded.
//                In GRANT the grant is held until a transferred beat carries
//                last (or, with the timeout option, until max_beats beats have
//                moved); the pointer then moves to the released source so the
//                next search starts just after it.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus        - rr_mux_arbiter_if.master
//                             (req, last, out_ready in;
//                              sel, grant, out_valid, busy out)
//  Options     : ARB_TIMEOUT_EN - when defined, a per-grant beat counter
//                                 force-releases the grant after max_beats
//                                 transferred beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
  parameter int in_inputs = 16,
  parameter int log2ofin  = ($clog2(in_inputs) <= 0) ? 1 : $clog2(in_inputs),
  parameter int max_beats = 16
) (
  input  wire              clk,
  input  wire              rst,
  rr_mux_arbiter_if.master bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [log2ofin-1:0] ptr_reset = log2ofin'(in_inputs - 1);

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  state_t               state,    state_nx;
  logic [log2ofin-1:0]  ptr,      ptr_nx;     // last source that was served
  logic [log2ofin-1:0]  sel_q,    sel_nx;
  logic [in_inputs-1:0] grant_q,  grant_nx;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic busy_w;
  logic out_valid_w;
  logic xfer;
  logic pkt_end;     // the transferring beat closes the current grant

  assign busy_w      = (state == GRANT);
  // Valid follows the held source's request; a stalled source simply drops
  // valid while keeping the grant.
  assign out_valid_w = busy_w & bus.req[sel_q];
  assign xfer        = out_valid_w & bus.out_ready;

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_w;
  assign bus.out_valid = out_valid_w;

  // --------------------------------------------------------------------------
  // Optional beat limit
  // --------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int cnt_w = $clog2(max_beats + 1);
  localparam logic [cnt_w-1:0] beat_max = cnt_w'(max_beats);

  logic [cnt_w-1:0] beat_cnt, beat_cnt_nx;
  logic [cnt_w-1:0] beat_cnt_inc;

  assign beat_cnt_inc = beat_cnt + 1'b1;
  // The beat that brings the count to max_beats ends the grant exactly like
  // a beat carrying last; the source re-arbitrates for the remainder.
  assign pkt_end = bus.last[sel_q] | (beat_cnt_inc == beat_max);
`else
  assign pkt_end = bus.last[sel_q];
`endif

  // --------------------------------------------------------------------------
  // Round-robin search
  // Candidates are ptr+1, ptr+2, ... ptr+in_inputs, folded back at
  // in_inputs (not at 2**log2ofin) so unused select codes are never produced.
  // The last candidate is ptr itself, which lets a lone requester win again.
  // --------------------------------------------------------------------------
  logic                found;
  logic [log2ofin-1:0] winner;
  int                  cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= in_inputs; k++) begin
      cand = int'(ptr) + k;
      if (cand >= in_inputs) begin
        cand = cand - in_inputs;
      end
      if (!found && bus.req[cand[log2ofin-1:0]]) begin
        found  = 1'b1;
        winner = cand[log2ofin-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    sel_nx      = sel_q;
    grant_nx    = grant_q;
`ifdef ARB_TIMEOUT_EN
    beat_cnt_nx = beat_cnt;
`endif

    case (state)
      IDLE: begin
        if (found) begin
          sel_nx           = winner;
          grant_nx         = '0;
          grant_nx[winner] = 1'b1;
          state_nx         = GRANT;
`ifdef ARB_TIMEOUT_EN
          beat_cnt_nx      = '0;
`endif
        end
      end

      GRANT: begin
        // Without a transfer everything holds, so sel is stable while
        // out_valid is waiting on out_ready. Requests from other sources
        // are not looked at here.
        if (xfer) begin
`ifdef ARB_TIMEOUT_EN
          beat_cnt_nx = beat_cnt_inc;
`endif
          if (pkt_end) begin
            ptr_nx   = sel_q;
            grant_nx = '0;
            state_nx = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= ptr_reset;
      sel_q    <= '0;
      grant_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      beat_cnt <= '0;
`endif
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      sel_q    <= sel_nx;
      grant_q  <= grant_nx;
`ifdef ARB_TIMEOUT_EN
      beat_cnt <= beat_cnt_nx;
`endif
    end
  end

endmodule : rr_mux_arbiter
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_mux_arbiter
//  Description : Directed self-checking bench for rr_mux_arbiter with
//                16 sources. Inputs change 1 ns after the rising edge and
//                outputs are checked at that point, well clear of the edge.
//  Options     : ARB_TIMEOUT_EN - selects max_beats=4 and the split-packet
//                                 expectations in the long-packet step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  localparam int n = 16;
`ifdef ARB_TIMEOUT_EN
  localparam int mb = 4;
`else
  localparam int mb = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter_if #(.in_inputs(n)) bus ();

  rr_mux_arbiter #(
    .in_inputs (n),
    .max_beats (mb)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 32'(bus.grant), 32'h0);
    check({tag, ".busy"},  32'(bus.busy),  32'h0);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'h0);
  endtask

  initial begin
    int order [5];
    order = '{0, 5, 10, 15, 0};

    bus.req       = '0;
    bus.last      = '0;
    bus.out_ready = 1'b1;

    // ---------------- reset, then idle ----------------
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset");
    check("reset.sel", 32'(bus.sel), 32'h0);
    rst = 1'b0;
    tick();
    check_idle("idle_noreq");

    bus.req = 16'h0001;
    tick();
    check("first.grant", 32'(bus.grant), 32'h0001);
    check("first.sel",   32'(bus.sel),   32'h0);
    check("first.busy",  32'(bus.busy),  32'h1);
    check("first.valid", 32'(bus.out_valid), 32'h1);
    bus.last = 16'h0001;
    tick();
    check_idle("first.done");
    bus.req  = '0;
    bus.last = '0;

    // ---------------- rotation ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req  = 16'h8421;
    bus.last = 16'h8421;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rot%0d.grant", i), 32'(bus.grant), 32'h1 << order[i]);
      check($sformatf("rot%0d.sel", i),   32'(bus.sel),   32'(order[i]));
      tick();
      check($sformatf("rot%0d.bubble", i), 32'(bus.busy), 32'h0);
    end
    bus.req  = '0;
    bus.last = '0;

    // ---------------- backpressure (ptr=0) ----------------
    bus.req       = 16'h0008;
    bus.last      = 16'h0008;
    bus.out_ready = 1'b0;
    tick();
    check("bp.grant", 32'(bus.grant), 32'h0008);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp%0d.sel", i),   32'(bus.sel),       32'h3);
      check($sformatf("bp%0d.valid", i), 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    tick();
    check_idle("bp.done");
    bus.req  = '0;
    bus.last = '0;

    // ---------------- multi-beat lock (ptr=3) ----------------
    bus.req = 16'h0004;
    tick();
    check("mb.grant", 32'(bus.grant), 32'h0004);
    bus.req = 16'h0006;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("mb.beat%0d", i), 32'(bus.grant), 32'h0004);
    end
    bus.last = 16'h0004;
    tick();
    check_idle("mb.done");
    bus.last = '0;
    tick();
    check("mb.next.grant", 32'(bus.grant), 32'h0002);
    check("mb.next.sel",   32'(bus.sel),   32'h1);
    bus.last = 16'h0002;
    tick();
    check_idle("mb.next.done");
    bus.req  = '0;
    bus.last = '0;

    // ---------------- reset mid-packet (ptr=1) ----------------
    bus.req = 16'h0080;
    tick();
    check("rmid.grant", 32'(bus.grant), 32'h0080);
    tick();
    tick();
    check("rmid.held", 32'(bus.grant), 32'h0080);
    bus.req = 16'h0090;
    rst     = 1'b1;
    tick();
    check_idle("rmid.reset");
    check("rmid.reset.sel", 32'(bus.sel), 32'h0);
    rst = 1'b0;
    tick();
    check("rmid.low.grant", 32'(bus.grant), 32'h0010);
    check("rmid.low.sel",   32'(bus.sel),   32'h4);
    bus.last = 16'h0010;
    tick();
    check_idle("rmid.low.done");
    bus.req  = '0;
    bus.last = '0;

    // ---------------- long packet, 6 beats from source 0 (ptr=4) ----------
    bus.req = 16'h0001;
    tick();
    check("long.grant", 32'(bus.grant), 32'h0001);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("long.beat%0d", i), 32'(bus.busy), 32'h1);
    end
    tick();   // beat 4 transfers here
`ifdef ARB_TIMEOUT_EN
    check_idle("long.split");
    tick();
    check("long.regrant", 32'(bus.grant), 32'h0001);
    tick();   // beat 5
    check("long.beat5", 32'(bus.busy), 32'h1);
`else
    check("long.beat4", 32'(bus.busy), 32'h1);
    tick();   // beat 5
    check("long.beat5", 32'(bus.busy), 32'h1);
`endif
    bus.last = 16'h0001;
    tick();   // beat 6 carries last
    check_idle("long.done");
    bus.req  = '0;
    bus.last = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_rr_mux_arbiter
`default_nettype wire
